// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA constants and pixel-arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned c_H_RES       = 160;
    localparam int unsigned c_V_RES       = 120;
    localparam logic [8:0]  c_TRANSPARENT = 9'h1FF;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Channel-index width that stays legal for a single channel.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_arbiter_if
// Description : Drawing-channel handshake and plot-stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_arbiter_if #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 9,
    parameter int unsigned CNT_W    = 16
);
    logic [N_CH-1:0]          in_valid;
    logic [N_CH-1:0]          in_last;
    logic [N_CH*X_W-1:0]      in_x;
    logic [N_CH*Y_W-1:0]      in_y;
    logic [N_CH*COLOUR_W-1:0] in_colour;
    logic [N_CH-1:0]          in_ready;
    logic                     stall;
    logic                     clr_cnt;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COLOUR_W-1:0]      colour;
    logic                     plot;
    logic                     busy;
    logic [CNT_W-1:0]         plot_cnt;
    logic [CNT_W-1:0]         drop_cnt;

    modport master (
        output in_valid, in_last, in_x, in_y, in_colour, stall, clr_cnt,
        input  in_ready, x, y, colour, plot, busy, plot_cnt, drop_cnt
    );

    modport slave (
        input  in_valid, in_last, in_x, in_y, in_colour, stall, clr_cnt,
        output in_ready, x, y, colour, plot, busy, plot_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : First-set picker starting at a rotating pointer (wraps).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  wire logic [N_CH-1:0]  i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N_CH-1:0]  o_grant,
    output logic      [IDX_W-1:0] o_idx
);
    always_comb begin
        int unsigned v_pos;
        logic        v_found;
        o_grant = '0;
        o_idx   = '0;
        v_found = 1'b0;
        v_pos   = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            v_pos = (32'(i_ptr) + k) % N_CH;
            if (!v_found && i_req[v_pos]) begin
                v_found        = 1'b1;
                o_grant[v_pos] = 1'b1;
                o_idx          = IDX_W'(v_pos);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_pixel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_arbiter
// Description : Merges N drawing channels into one filtered, registered plot
//               stream with sprite-length grant locking and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned            N_CH        = 4,
    parameter int unsigned            X_W         = 8,
    parameter int unsigned            Y_W         = 7,
    parameter int unsigned            COLOUR_W    = 9,
    parameter int unsigned            H_RES       = c_H_RES,
    parameter int unsigned            V_RES       = c_V_RES,
    parameter bit                     KEY_EN      = 1'b1,
    parameter logic [COLOUR_W-1:0]    TRANSPARENT = COLOUR_W'(c_TRANSPARENT),
    parameter bit                     MASK_X0     = 1'b1,
    parameter bit                     RR_MODE     = 1'b1,
    parameter int unsigned            CNT_W       = 16
) (
    input wire logic          clk,
    input wire logic          reset,
    vga_pixel_arbiter_if.slave bus
);
    localparam int unsigned c_IDX_W = idx_width(N_CH);

    arb_state_t           r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_IDX_W-1:0]   w_pick_ptr, w_pick_idx, w_sel, w_sel_inc;
    logic [N_CH-1:0]      w_pick_grant, w_ready;
    logic                 w_xfer, w_last, w_drop;
    logic [X_W-1:0]       w_px_x;
    logic [Y_W-1:0]       w_px_y;
    logic [COLOUR_W-1:0]  w_px_colour;

    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [COLOUR_W-1:0]  r_colour;
    logic                 r_plot;
    logic [CNT_W-1:0]     r_plot_cnt, r_drop_cnt;

    assign w_pick_ptr = RR_MODE ? r_rr_ptr : '0;

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .i_req   (bus.in_valid),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // Ready never looks at pixel data, only at state, valid, pointer and stall.
    always_comb begin
        w_ready = '0;
        w_sel   = (r_state == ST_IDLE) ? w_pick_idx : r_owner;
        if (!reset && !bus.stall) begin
            if (r_state == ST_IDLE) begin
                w_ready = w_pick_grant;
            end else begin
                w_ready[r_owner] = bus.in_valid[r_owner];
            end
        end
    end

    assign w_xfer      = |(bus.in_valid & w_ready);
    assign w_last      = bus.in_last[w_sel];
    assign w_px_x      = bus.in_x[w_sel*X_W +: X_W];
    assign w_px_y      = bus.in_y[w_sel*Y_W +: Y_W];
    assign w_px_colour = bus.in_colour[w_sel*COLOUR_W +: COLOUR_W];
    assign w_sel_inc   = (w_sel == c_IDX_W'(N_CH - 1)) ? '0 : w_sel + 1'b1;

    assign w_drop = (KEY_EN && (w_px_colour == TRANSPARENT)) ||
                    (MASK_X0 && (w_px_x == '0)) ||
                    (32'(w_px_x) >= H_RES) ||
                    (32'(w_px_y) >= V_RES);

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_xfer) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                if (RR_MODE) begin
                    w_rr_ptr_nxt = w_sel_inc;
                end
            end else begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Coordinates follow every transfer; only accepted pixels strobe plot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_xfer && !w_drop;
            if (w_xfer) begin
                r_x      <= w_px_x;
                r_y      <= w_px_y;
                r_colour <= w_px_colour;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clr_cnt) begin
            r_plot_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_xfer) begin
            if (w_drop) begin
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else if (r_plot_cnt != '1) begin
                r_plot_cnt <= r_plot_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.colour   = r_colour;
    assign bus.plot     = r_plot;
    assign bus.busy     = (r_state == ST_LOCKED);
    assign bus.plot_cnt = r_plot_cnt;
    assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/vga_pixel_arbiter.md
# vga_pixel_arbiter

Parametrised pixel-write front end for the VGA adapter: merges N independent drawing channels into one registered plot stream with {x, y, colour, plot}. Each channel is a sprite/background drawer using a valid/ready handshake. The block arbitrates between channels, holds a grant for the length of a sprite, and drops transparent, masked or off-screen pixels. It also keeps plot and drop statistics. It sits between the game-flow datapath and `vga_adapter`, replacing the single-source output register stage.

## Interface
- `N_CH`, 4: number of drawing channels (1..8).
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `COLOUR_W`, 9: colour width.
- `H_RES`, 160: pixels with x ≥ H_RES are dropped.
- `V_RES`, 120: pixels with y ≥ V_RES are dropped.
- `KEY_EN`, 1: enable the transparent colour key.
- `TRANSPARENT`, 9'h1FF: key colour. Pixels with this colour are dropped when KEY_EN=1.
- `MASK_X0`, 1: drop pixels with x == 0 (the column-0 guard).
- `RR_MODE`, 1: 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`, in, 1: system clock (CLOCK_50 at top).
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, N_CH: channel i presents a pixel.
- `in_last`, in, N_CH: pixel i is the last of its sprite and releases the grant.
- `in_x`, in, N_CH*X_W: packed coordinates, channel i at bits [i*X_W +: X_W].
- `in_y`, in, N_CH*Y_W: packed, same layout as `in_x`.
- `in_colour`, in, N_CH*COLOUR_W: packed, same layout as `in_x`.
- `in_ready`, out, N_CH: one-hot or zero; channel i may transfer this cycle.
- `stall`, in, 1: when high, no channel is ready and no pixel is accepted.
- `x`, out, X_W: registered pixel x.
- `y`, out, Y_W: registered pixel y.
- `colour`, out, COLOUR_W: registered colour.
- `plot`, out, 1: write strobe to `vga_adapter`.
- `busy`, out, 1: a channel currently holds a grant.
- `plot_cnt`, out, CNT_W: number of pixels plotted.
- `drop_cnt`, out, CNT_W: number of pixels accepted but not plotted.
- `clr_cnt`, in, 1: synchronously zero both counters.

## Operation
- A transfer on channel i occurs when `in_valid[i] & in_ready[i]`; at most one transfer per cycle.
- States: IDLE, LOCKED(owner).
- IDLE, no `stall`, some `in_valid` set:
  - Select a winner: fixed priority picks the lowest index; RR picks the first valid channel at or after `rr_ptr` (wrapping).
  - `in_ready[winner]=1` combinationally.
  - On the transfer, if `in_last` is 0, go to LOCKED(winner). If `in_last` is 1, stay IDLE.
- LOCKED(owner):
  - Only `in_ready[owner]` may be 1; it is high when the owner is valid and `stall` is low.
  - The owner dropping `in_valid` keeps the lock. No other channel is served.
  - A transfer with `in_last=1` returns to IDLE and sets `rr_ptr = owner+1 mod N_CH`.
- In RR mode, `rr_ptr` also advances to winner+1 on a single-pixel (`in_last`) transfer from IDLE. In fixed mode, `rr_ptr` stays 0.
- Filter on each transferred pixel. It is dropped if any of the following holds:
  - KEY_EN and colour == TRANSPARENT;
  - MASK_X0 and x == 0;
  - x ≥ H_RES;
  - y ≥ V_RES.
- Otherwise the pixel is plotted.
- Dropped pixels are still consumed: the handshake completes and the lock/last logic applies.
- Counters increment by one per plotted or dropped pixel and saturate at all-ones. `clr_cnt` takes precedence over an increment in the same cycle.
- `busy` = state is LOCKED.

## Timing
- `in_ready` is combinational from state, `in_valid`, `rr_ptr` and `stall`. There is no combinational path from `in_x`/`in_y`/`in_colour` to `in_ready`.
- Output latency is 1 cycle: a transfer in cycle t gives `x`/`y`/`colour` and `plot` in cycle t+1.
- `plot` is 1 for exactly one cycle per plotted pixel. `x`/`y`/`colour` update on every transfer, including drops; plot stays 0 on a drop.
- Throughput is one pixel per cycle, including back-to-back sprites from different channels (IDLE re-arbitrates in the same cycle it is entered).
- `stall` high forces `in_ready = 0` in that cycle. The state, lock and `rr_ptr` are unchanged.
- Reset (at any time, including mid-sprite):
  - state IDLE, `rr_ptr` 0;
  - `x`, `y`, `colour`, `plot`, `busy`, `in_ready`, `plot_cnt`, `drop_cnt` all 0;
  - any pixel in flight is lost.
- N_CH=1: degenerates to a filter register; the lock logic remains but has no effect on ordering.

## Structure
- The shared package `vga_pkg` holds the default H_RES/V_RES, the default TRANSPARENT key, and the state encoding (IDLE/LOCKED).
- One natural sub-module: `rr_pick`, a combinational N_CH-wide priority picker with rotating start pointer. It returns a one-hot grant plus an encoded index and is shared by both modes (pointer tied to 0 for fixed mode).
- Top-level integration: the game-flow datapath drives channel 0. Additional drawers (tower, car, HUD) occupy channels 1..N_CH-1.

## Test plan
- Reset, then ch0 sends (x=5, y=7, colour=9'h0F0, last=1) → next cycle: `plot`=1, x=5, y=7, colour=9'h0F0; `plot_cnt`=1.
- ch0 sends colour 9'h1FF at (3,3), then (0,10) colour 9'h007, then (200,5) → `plot` stays 0 for all three; `drop_cnt`=3, `plot_cnt`=0; all three handshakes complete.
- RR_MODE=1: ch1 and ch2 each stream 4-pixel sprites (last on pixel 4) while both stay valid → order is ch1×4, ch2×4, ch1×4; `in_ready` is never high for the non-owner; `busy` is high within each sprite.
- RR_MODE=0: ch0 and ch3 are both valid with single-pixel sprites → ch0 is always served; ch3 is served only once ch0 deasserts valid.
- Mid-sprite: ch2 is locked, `stall` is held for 3 cycles, then ch2's valid drops for 2 cycles → no pixel is accepted from any channel and the lock is retained. Assert `reset` after pixel 2 → all outputs 0, IDLE, and ch0 is granted first afterwards.
- Preload `plot_cnt` to all-ones by streaming 2^CNT_W pixels (CNT_W=4 build: 16) → the counter holds at 15 on the 17th pixel. `clr_cnt` together with a plot → the counter reads 0.
